frmbuf_wr_burst_ctrl: RTL and testbench

FRMBUF_WR_BURST_CTRL -- requirements
Module: frmbuf_wr_burst_ctrl

---
 rtl/frmbuf_wr_burst_ctrl.sv | 163 ++++++++++++++++
 tb/tb_frmbuf_wr_burst_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frmbuf_wr_burst_ctrl.sv
// Frame-buffer write burst controller: drains an FWFT FIFO into DDR3 write bursts of up to BURST_LEN words.
// Optional macro FRMBUF_WR_OVERRUN_CHK_EN builds the sticky frame-overrun flag on o_err.
module frmbuf_wr_burst_ctrl #(
  parameter int BURST_LEN = 64,
  parameter int ADDR_STEP = 8,
  parameter int FRM_WORDS = 259200
) (
  input  logic         i_ddr3_clk,
  input  logic         i_rst_n,
  input  logic         i_frm_start,
  input  logic [26:0]  i_addr_inital,
  input  logic [10:0]  i_fifo_rd_cnt,
  input  logic [255:0] i_fifo_dout,
  output logic         o_fifo_rd_en,
  output logic         o_app_en,
  output logic [2:0]   o_app_cmd,
  output logic [26:0]  o_app_addr,
  input  logic         i_app_rdy,
  output logic         o_app_wdf_wren,
  output logic         o_app_wdf_end,
  output logic [255:0] o_app_wdf_data,
  input  logic         i_app_wdf_rdy,
  output logic         o_busy,
  output logic         o_err
);

  localparam int WD_W = ($clog2(FRM_WORDS + 1) > 9) ? $clog2(FRM_WORDS + 1) : 9;
  localparam logic [WD_W-1:0] FRM_W  = WD_W'(FRM_WORDS);
  localparam logic [WD_W-1:0] BL_MAX = WD_W'(BURST_LEN);
  localparam logic [26:0]     STEP   = 27'(ADDR_STEP);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_CMD} state_e;

  state_e          state_q;
  logic [WD_W-1:0] words_done_q;
  logic [7:0]      bl_q, cnt_q;
  logic [26:0]     addr_q, pend_addr_q;
  logic            pend_q, wren_q, app_en_q, busy_q;

  logic [WD_W-1:0] remain, words_d;
  logic [7:0]      bl_d;
  logic            fifo_ok, beat_acc, cmd_acc, last_unit, restart;
  logic [26:0]     reload_addr;

  always_comb begin
    remain      = FRM_W - words_done_q;
    bl_d        = (remain < BL_MAX) ? remain[7:0] : BL_MAX[7:0];
    fifo_ok     = i_fifo_rd_cnt >= {3'b000, bl_d};
    beat_acc    = wren_q & i_app_wdf_rdy;
    cmd_acc     = app_en_q & i_app_rdy;
    last_unit   = (cnt_q == bl_q - 8'd1);
    words_d     = words_done_q + {{(WD_W-8){1'b0}}, bl_q};
    // A start pulse arriving this very cycle supersedes an older pending one.
    restart     = pend_q | i_frm_start;
    reload_addr = i_frm_start ? i_addr_inital : pend_addr_q;
  end

  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      words_done_q <= '0;
      bl_q         <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      pend_addr_q  <= '0;
      pend_q       <= 1'b0;
      wren_q       <= 1'b0;
      app_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (i_frm_start && state_q != S_IDLE) begin
        pend_q      <= 1'b1;
        pend_addr_q <= i_addr_inital;
      end
      case (state_q)
        S_IDLE: begin
          if (i_frm_start) begin
            addr_q       <= i_addr_inital;
            words_done_q <= '0;
            pend_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (restart) begin
            addr_q       <= reload_addr;
            words_done_q <= '0;
            pend_q       <= 1'b0;
          end else if (fifo_ok) begin
            bl_q    <= bl_d;
            cnt_q   <= '0;
            wren_q  <= 1'b1;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_acc) begin
            if (last_unit) begin
              wren_q   <= 1'b0;
              app_en_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= S_CMD;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_CMD: begin
          if (cmd_acc) begin
            addr_q <= addr_q + STEP;
            if (last_unit) begin
              app_en_q <= 1'b0;
              cnt_q    <= '0;
              if (restart) begin
                // New frame: skip the old frame's remaining bursts entirely.
                addr_q       <= reload_addr;
                words_done_q <= '0;
                pend_q       <= 1'b0;
                state_q      <= S_WAIT;
              end else if (words_d == FRM_W) begin
                words_done_q <= words_d;
                busy_q       <= 1'b0;
                state_q      <= S_IDLE;
              end else begin
                words_done_q <= words_d;
                state_q      <= S_WAIT;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FRMBUF_WR_OVERRUN_CHK_EN
  logic err_q;
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (i_frm_start && state_q != S_IDLE && words_done_q < FRM_W) begin
      err_q <= 1'b1;
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // FWFT head only moves on pops, which happen on clock edges.
  assign o_fifo_rd_en   = beat_acc;
  assign o_app_wdf_data = i_fifo_dout;
  assign o_app_wdf_wren = wren_q;
  assign o_app_wdf_end  = wren_q;
  assign o_app_en       = app_en_q;
  assign o_app_cmd      = 3'b000;
  assign o_app_addr     = addr_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_frmbuf_wr_burst_ctrl.sv
// Bench for frmbuf_wr_burst_ctrl: vector table for start-up, random frames vs a stream/address model.
module tb_frmbuf_wr_burst_ctrl;
  localparam int BL = 64, FW = 100, STEP = 8;
`ifdef FRMBUF_WR_OVERRUN_CHK_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic         clk = 1'b0, rst_n, frm_start, app_rdy, wdf_rdy;
  logic [26:0]  addr_init;
  logic [10:0]  fifo_cnt;
  logic [255:0] fifo_dout;
  logic         fifo_rd_en, app_en, wdf_wren, wdf_end, busy, err;
  logic [2:0]   app_cmd;
  logic [26:0]  app_addr;
  logic [255:0] wdf_data;

  always #5 clk = ~clk;

  frmbuf_wr_burst_ctrl #(.BURST_LEN(BL), .ADDR_STEP(STEP), .FRM_WORDS(FW)) dut (
    .i_ddr3_clk(clk), .i_rst_n(rst_n), .i_frm_start(frm_start), .i_addr_inital(addr_init),
    .i_fifo_rd_cnt(fifo_cnt), .i_fifo_dout(fifo_dout), .o_fifo_rd_en(fifo_rd_en),
    .o_app_en(app_en), .o_app_cmd(app_cmd), .o_app_addr(app_addr), .i_app_rdy(app_rdy),
    .o_app_wdf_wren(wdf_wren), .o_app_wdf_end(wdf_end), .o_app_wdf_data(wdf_data),
    .i_app_wdf_rdy(wdf_rdy), .o_busy(busy), .o_err(err));

  typedef struct {
    bit start; int push; bit wrdy; bit ardy;
    bit exp_wren; bit exp_en; bit exp_busy; int exp_cnt;
  } vec_t;
  vec_t tbl[8];

  // Model: FIFO contents, every word ever pushed (beats must replay it in order), expected commands.
  logic [255:0] fifo[$];
  logic [255:0] sent[$];
  logic [26:0]  exp_addr[$];
  int beat_idx, cmd_total, exp_beats, beats_in_frame, frame_limit;
  bit restart_pend;
  logic         prev_wren, prev_wrdy, prev_en, prev_ardy;
  logic [255:0] prev_data;
  logic [26:0]  prev_addr;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void sync_fifo();
    fifo_cnt  = 11'(fifo.size());
    fifo_dout = (fifo.size() > 0) ? fifo[0] : '0;
  endfunction

  function automatic void push_words(input int n);
    logic [255:0] w;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
      fifo.push_back(w);
      sent.push_back(w);
    end
    sync_fifo();
  endfunction

  function automatic void note_frame(input logic [26:0] base);
    for (int i = 0; i < FW; i++) exp_addr.push_back(base + 27'(i * STEP));
    beats_in_frame = 0;
    frame_limit    = FW;
    restart_pend   = 0;
    exp_beats     += FW;
  endfunction

  // Start during DATA: the burst in flight completes, the rest of the old frame is dropped.
  function automatic void note_restart(input logic [26:0] base);
    int k;
    k = (beats_in_frame / BL + 1) * BL;
    if (k > FW) k = FW;
    for (int i = 0; i < FW - k; i++) void'(exp_addr.pop_back());
    exp_beats   += k - FW;
    frame_limit  = k;
    restart_pend = 1;
    for (int i = 0; i < FW; i++) exp_addr.push_back(base + 27'(i * STEP));
    exp_beats += FW;
  endfunction

  function automatic void resync();
    fifo.delete(); sent.delete(); exp_addr.delete();
    beat_idx = 0; cmd_total = 0; exp_beats = 0; beats_in_frame = 0;
    frame_limit = FW; restart_pend = 0;
    prev_wren = 0; prev_wrdy = 0; prev_en = 0; prev_ardy = 0;
    prev_data = '0; prev_addr = '0;
    sync_fifo();
  endfunction

  // Called in the negedge region after inputs are set; returns at the following negedge.
  task automatic tick();
    logic s_wren, s_wrdy, s_en, s_ardy, s_rd;
    logic [255:0] s_data;
    logic [26:0]  s_addr;
    int s_cnt, exp_bl;
    #1;
    s_wren = wdf_wren; s_wrdy = wdf_rdy; s_en = app_en; s_ardy = app_rdy; s_rd = fifo_rd_en;
    s_data = wdf_data; s_addr = app_addr; s_cnt = fifo.size();
    chk("rd_en", 256'(s_rd), 256'(s_wren & s_wrdy));
    if (s_rd) chk("fifo_nonempty", 256'(s_cnt > 0), 256'd1);
    if (s_wren) chk("wdf_end", 256'(wdf_end), 256'd1);
    if (s_wren && !prev_wren) begin
      exp_bl = (FW - beats_in_frame < BL) ? FW - beats_in_frame : BL;
      chk("burst_fill", 256'(s_cnt >= exp_bl), 256'd1);
    end
    if (prev_wren && !prev_wrdy) begin
      chk("wren_hold", 256'(s_wren), 256'd1);
      chk("data_hold", s_data, prev_data);
    end
    if (prev_en && !prev_ardy) begin
      chk("en_hold", 256'(s_en), 256'd1);
      chk("addr_hold", 256'(s_addr), 256'(prev_addr));
    end
    if (s_wren && s_wrdy) begin
      if (beat_idx < sent.size()) chk("wdf_data", s_data, sent[beat_idx]);
      else chk("beat_extra", 256'(beat_idx), 256'(sent.size()));
    end
    if (s_en && s_ardy) begin
      chk("app_cmd", 256'(app_cmd), 256'd0);
      chk("cmd_after_data", 256'(cmd_total < beat_idx), 256'd1);
      if (exp_addr.size() > 0) chk("cmd_addr", 256'(s_addr), 256'(exp_addr.pop_front()));
      else chk("cmd_extra", 256'(s_addr), 256'd0 - 256'd1);
    end
    @(posedge clk);
    @(negedge clk);
    if (s_rd && fifo.size() > 0) void'(fifo.pop_front());
    if (s_wren && s_wrdy) begin
      beat_idx++;
      beats_in_frame++;
      if (restart_pend && beats_in_frame == frame_limit) begin
        beats_in_frame = 0; frame_limit = FW; restart_pend = 0;
      end
    end
    if (s_en && s_ardy) cmd_total++;
    prev_wren = s_wren; prev_wrdy = s_wrdy; prev_en = s_en; prev_ardy = s_ardy;
    prev_data = s_data; prev_addr = s_addr;
    sync_fifo();
  endtask

  // mode 0: always ready; 1: wdf_rdy toggles; 2: random ready and trickled FIFO fill
  task automatic run_to_idle(input int mode, input int budget);
    int cyc = 0, n;
    while (busy && cyc < budget) begin
      case (mode)
        0: begin wdf_rdy = 1; app_rdy = 1; end
        1: begin wdf_rdy = cyc[0]; app_rdy = 1; end
        default: begin wdf_rdy = ($urandom % 4) != 0; app_rdy = ($urandom % 4) != 0; end
      endcase
      n = exp_beats - sent.size();
      if (n > 0) push_words((mode == 2) ? ((n < 3) ? $urandom_range(0, n) : $urandom_range(0, 3)) : n);
      tick();
      cyc++;
    end
    wdf_rdy = 1; app_rdy = 1;
    chk("frame_end_busy", 256'(busy), 256'd0);
    chk("frame_cmds_left", 256'(exp_addr.size()), 256'd0);
    chk("frame_beats", 256'(beat_idx), 256'(exp_beats));
    chk("frame_idle_wren", 256'(wdf_wren), 256'd0);
    chk("frame_idle_en", 256'(app_en), 256'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wren"}, 256'(wdf_wren), 256'd0);
    chk({tag, "_end"}, 256'(wdf_end), 256'd0);
    chk({tag, "_en"}, 256'(app_en), 256'd0);
    chk({tag, "_rd_en"}, 256'(fifo_rd_en), 256'd0);
    chk({tag, "_busy"}, 256'(busy), 256'd0);
    chk({tag, "_err"}, 256'(err), 256'd0);
    chk({tag, "_addr"}, 256'(app_addr), 256'd0);
    chk({tag, "_cmd"}, 256'(app_cmd), 256'd0);
  endtask

  initial begin
    logic [26:0] base;
    int cyc;
    rst_n = 0; frm_start = 0; addr_init = '0; app_rdy = 1; wdf_rdy = 1;
    resync();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1;

    // start-up: FIFO one word short holds WAIT, the 64th word launches DATA, stalls hold the beat
    tbl[0] = '{1,  0, 1, 1, 0, 0, 1,  0};
    tbl[1] = '{0, 63, 1, 1, 0, 0, 1, 63};
    tbl[2] = '{0,  0, 1, 1, 0, 0, 1, 63};
    tbl[3] = '{0,  1, 1, 1, 1, 0, 1, 64};
    tbl[4] = '{0,  0, 0, 1, 1, 0, 1, 64};
    tbl[5] = '{0,  0, 1, 1, 1, 0, 1, 63};
    tbl[6] = '{0,  0, 0, 1, 1, 0, 1, 63};
    tbl[7] = '{0, 36, 1, 1, 1, 0, 1, 98};
    addr_init = 27'h0800000;
    for (int i = 0; i < 8; i++) begin
      frm_start = tbl[i].start;
      if (tbl[i].start) note_frame(addr_init);
      push_words(tbl[i].push);
      wdf_rdy = tbl[i].wrdy; app_rdy = tbl[i].ardy;
      tick();
      frm_start = 0;
      chk($sformatf("tbl%0d_wren", i), 256'(wdf_wren), 256'(tbl[i].exp_wren));
      chk($sformatf("tbl%0d_en", i), 256'(app_en), 256'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_busy", i), 256'(busy), 256'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_cnt", i), 256'(fifo.size()), 256'(tbl[i].exp_cnt));
    end
    run_to_idle(1, 3000);
    chk("err_clean", 256'(err), 256'd0);

    // random frames, first one wrapping past the top of the 27-bit space
    for (int f = 0; f < 4; f++) begin
      base = (f == 0) ? 27'h7FFFFC0 : 27'($urandom);
      addr_init = base; frm_start = 1; note_frame(base);
      tick();
      frm_start = 0;
      run_to_idle(2, 4000);
    end
    chk("err_after_frames", 256'(err), 256'd0);

    // new frame start in the middle of DATA
    addr_init = 27'h0100000; frm_start = 1; note_frame(addr_init);
    push_words(FW);
    tick();
    frm_start = 0;
    cyc = 0;
    while (beats_in_frame < 10 && cyc < 200) begin tick(); cyc++; end
    chk("reach_data", 256'(beats_in_frame >= 10), 256'd1);
    addr_init = 27'h0200000; frm_start = 1; note_restart(addr_init);
    tick();
    frm_start = 0;
    chk("overrun_flag", 256'(err), 256'(EXP_OVR));
    run_to_idle(0, 2000);
    chk("overrun_sticky", 256'(err), 256'(EXP_OVR));

    // reset pulse while commands are going out
    addr_init = 27'h0300000; frm_start = 1; note_frame(addr_init);
    push_words(FW);
    tick();
    frm_start = 0;
    cyc = 0;
    while (!app_en && cyc < 300) begin tick(); cyc++; end
    chk("reach_cmd", 256'(app_en), 256'd1);
    repeat (3) tick();
    rst_n = 0;
    #1;
    chk_reset_vals("midcmd_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    resync();
    push_words(80);
    repeat (20) tick();
    chk("no_traffic_busy", 256'(busy), 256'd0);
    chk("no_traffic_fifo", 256'(fifo.size()), 256'd80);
    chk("no_traffic_beats", 256'(beat_idx), 256'd0);
    addr_init = 27'h0400000; frm_start = 1; note_frame(addr_init);
    tick();
    frm_start = 0;
    run_to_idle(2, 4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
